// File: rtl/irq_dispatch8_pkg.sv
// Shared constants and types for the 8-way request dispatcher.
// The FSM state constants are plain localparams so older tools can use them too.
package irq_dispatch8_pkg;

  localparam int WAYS  = 8;
  localparam int IDX_W = 3;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam bit RR_ENABLE = 1'b1;

  typedef logic [WAYS-1:0]  way_vec_t;
  typedef logic [IDX_W-1:0] way_idx_t;

  typedef struct packed {
    logic     valid;
    way_idx_t idx;
    way_vec_t onehot;
  } grant_t;

  function automatic way_vec_t idx2onehot(input way_idx_t idx);
    return way_vec_t'(1) << idx;
  endfunction

endpackage

// File: rtl/irq_dispatch8_if.sv
// Request/grant bundle between the I/O request sources, the dispatcher and the
// CPU-side service logic. master = sources/service side, slave = dispatcher.
interface irq_dispatch8_if;
  import irq_dispatch8_pkg::*;

  way_vec_t req_in;
  way_vec_t mask;
  way_vec_t pending;
  logic     any_pending;
  logic     grant_valid;
  way_idx_t grant_idx;
  way_vec_t grant_onehot;
  logic     grant_ack;

  modport master (
    output req_in, mask, grant_ack,
    input  pending, any_pending, grant_valid, grant_idx, grant_onehot
  );

  modport slave (
    input  req_in, mask, grant_ack,
    output pending, any_pending, grant_valid, grant_idx, grant_onehot
  );

endinterface

// File: rtl/irq_dispatch8_rr_pick8.sv
// Combinational round-robin picker: first set bit at or above i_ptr, wrapping 7->0.
// Rotate right by the pointer, take the lowest set bit, then add the pointer back.
module rr_pick8
  import irq_dispatch8_pkg::*;
(
  input  way_vec_t i_req,
  input  way_idx_t i_ptr,
  output logic     o_found,
  output way_idx_t o_idx
);

  way_vec_t w_rot;
  way_idx_t w_off;

  always_comb begin
    w_rot = '0;
    for (int i = 0; i < WAYS; i++)
      w_rot[i] = i_req[IDX_W'(i) + i_ptr];
  end

  // Descending scan so the lowest set bit is the last one written.
  always_comb begin
    w_off = '0;
    for (int i = WAYS - 1; i >= 0; i--)
      if (w_rot[i]) w_off = IDX_W'(i);
  end

  assign o_found = |i_req;
  assign o_idx   = w_off + i_ptr;

endmodule

// File: rtl/irq_dispatch8.sv
// Responder for the 8-way "any request" line: sticky pending flags, any_pending
// summary and a one-at-a-time valid/ack grant (round-robin or fixed priority).
module irq_dispatch8
  import irq_dispatch8_pkg::*;
#(
  parameter int WAYS = 8,
  parameter bit RR   = RR_ENABLE
) (
  input logic           clk,
  input logic           rst_n,
  irq_dispatch8_if.slave io_bus
);

  localparam way_vec_t ALL_WAYS = way_vec_t'((1 << WAYS) - 1);

  logic [0:0] r_state;
  way_vec_t   r_pending;
  logic       r_any;
  grant_t     r_grant;
  way_idx_t   r_rr_ptr;

  logic       w_ack;
  way_vec_t   w_clr;
  way_vec_t   w_pend_nxt;
  way_vec_t   w_elig;
  logic       w_found;
  way_idx_t   w_win;

  assign w_ack = (r_state == ST_GRANT) && io_bus.grant_ack;
  assign w_clr = w_ack ? idx2onehot(r_grant.idx) : '0;

  // A new request on the way being cleared keeps its flag set.
  assign w_pend_nxt = (r_pending & ~w_clr) | io_bus.req_in;
  assign w_elig     = r_pending & io_bus.mask & ALL_WAYS;

  if (RR) begin : g_rr
    rr_pick8 u_pick (
      .i_req   (w_elig),
      .i_ptr   (r_rr_ptr),
      .o_found (w_found),
      .o_idx   (w_win)
    );
  end else begin : g_fixed
    rr_pick8 u_pick (
      .i_req   (w_elig),
      .i_ptr   ('0),
      .o_found (w_found),
      .o_idx   (w_win)
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_pending <= '0;
      r_any     <= 1'b0;
      r_grant   <= '0;
      r_rr_ptr  <= '0;
    end else begin
      r_pending <= w_pend_nxt;
      r_any     <= |(w_pend_nxt & io_bus.mask & ALL_WAYS);
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant.valid  <= 1'b1;
            r_grant.idx    <= w_win;
            r_grant.onehot <= idx2onehot(w_win);
            r_state        <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // Winner is frozen until acked; mask/pending changes are ignored here.
          if (io_bus.grant_ack) begin
            r_grant.valid  <= 1'b0;
            r_grant.onehot <= '0;
            r_rr_ptr       <= r_grant.idx + 3'd1;
            r_state        <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io_bus.pending      = r_pending;
  assign io_bus.any_pending  = r_any;
  assign io_bus.grant_valid  = r_grant.valid;
  assign io_bus.grant_idx    = r_grant.idx;
  assign io_bus.grant_onehot = r_grant.onehot;

endmodule
